dac_serial_tx: RTL and testbench

Dual-channel serial transmitter that drives two 12-bit DACs sharing one serial clock and one frame-sync line. It accepts parallel words pdata1/pdata2 over a valid/ready handshake and shifts out one 16-bit frame per accepted pair: 4 control bits, then 12 data bits, MSB first. It is the output-side counterpart of the dual-channel ADC capture path and runs in the clk_20M domain.

---
 rtl/dac_tx_pkg.sv | 17 +
 rtl/dac_sclk_gen.sv | 34 +++
 rtl/dac_serial_tx.sv | 134 +++++++++++++
 tb/tb_dac_serial_tx.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_tx_pkg.sv
// Shared constants and FSM state type for the dual-channel DAC serial transmitter.
package dac_tx_pkg;

  localparam int FRAME_W = 16;
  localparam int DATA_W  = 12;
  localparam int CTRL_W  = 4;

  localparam logic [CTRL_W-1:0] CTRL1_DEFAULT = 4'b0000;
  localparam logic [CTRL_W-1:0] CTRL2_DEFAULT = 4'b0000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

endpackage

// File: rtl/dac_sclk_gen.sv
// DAC serial clock generator: half-period counter, fall/rise strobes and the DAC_clk register.
module dac_sclk_gen #(
  parameter int HALF_DIV = 2
) (
  input  logic clk_20M,
  input  logic reset,
  input  logic en,
  output logic fall_tick,
  output logic rise_tick,
  output logic DAC_clk
);

  logic [3:0] half_cnt;
  logic       tick;

  // Strobes flag the edge about to happen, so the FSM acts on the same clk_20M edge DAC_clk toggles.
  assign tick      = en && (half_cnt == 4'(HALF_DIV - 1));
  assign fall_tick = tick && DAC_clk;
  assign rise_tick = tick && !DAC_clk;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_20M) begin
    if (reset || !en) begin
      half_cnt <= '0;
      DAC_clk  <= 1'b1;
    end else if (tick) begin
      half_cnt <= '0;
      DAC_clk  <= ~DAC_clk;
    end else begin
      half_cnt <= half_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/dac_serial_tx.sv
// Dual-channel 16-bit-frame serial transmitter for two 12-bit DACs sharing DAC_clk and sync_n,
// with a one-deep holding buffer that gives look-ahead while a frame is shifting.
module dac_serial_tx
  import dac_tx_pkg::*;
#(
  parameter int                HALF_DIV  = 2,
  parameter logic [CTRL_W-1:0] CTRL1     = CTRL1_DEFAULT,
  parameter logic [CTRL_W-1:0] CTRL2     = CTRL2_DEFAULT,
  parameter int                SYNC_HIGH = 4
) (
  input  logic              clk_20M,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pdata1,
  input  logic [DATA_W-1:0] pdata2,
  output logic              DAC_clk,
  output logic              sync_n,
  output logic              Dout1,
  output logic              Dout2,
  output logic              busy,
  output logic              done
);

  state_t               state;
  logic                 full;
  logic [DATA_W-1:0]    hold1;
  logic [DATA_W-1:0]    hold2;
  logic [FRAME_W-1:0]   frame1;
  logic [FRAME_W-1:0]   frame2;
  logic [FRAME_W-2:0]   sh1;
  logic [FRAME_W-2:0]   sh2;
  logic [4:0]           bit_cnt;
  logic [3:0]           gap_cnt;
  logic                 accept;
  logic                 gap_end;
  logic                 load;
  logic                 fall_tick;
  logic                 rise_tick;

  assign in_ready = !full;
  assign accept   = in_valid && !full;
  assign gap_end  = (state == GAP) && (gap_cnt == 4'(SYNC_HIGH - 1));
  assign load     = full && ((state == IDLE) || gap_end);
  assign frame1   = {CTRL1, hold1};
  assign frame2   = {CTRL2, hold2};

  dac_sclk_gen #(
    .HALF_DIV(HALF_DIV)
  ) u_sclk (
    .clk_20M  (clk_20M),
    .reset    (reset),
    .en       (state == SHIFT),
    .fall_tick(fall_tick),
    .rise_tick(rise_tick),
    .DAC_clk  (DAC_clk)
  );

  // NOTE: only the full flag is reset; the data words are don't-care while full is clear.
  always_ff @(posedge clk_20M) begin
    if (reset) begin
      full <= 1'b0;
    end else if (accept) begin
      full <= 1'b1;
    end else if (load) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk_20M) begin
    if (accept) begin
      hold1 <= pdata1;
      hold2 <= pdata2;
    end
  end

  always_ff @(posedge clk_20M) begin
    if (reset) begin
      state   <= IDLE;
      sync_n  <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      Dout1   <= 1'b0;
      Dout2   <= 1'b0;
      sh1     <= '0;
      sh2     <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        // Frame start: MSB goes straight onto Dout, the remaining 15 bits wait in the shifters.
        sh1     <= frame1[FRAME_W-2:0];
        sh2     <= frame2[FRAME_W-2:0];
        Dout1   <= frame1[FRAME_W-1];
        Dout2   <= frame2[FRAME_W-1];
        sync_n  <= 1'b0;
        busy    <= 1'b1;
        bit_cnt <= '0;
        state   <= SHIFT;
      end else begin
        case (state)
          SHIFT: begin
            if (fall_tick) begin
              bit_cnt <= bit_cnt + 5'd1;
            end else if (rise_tick) begin
              if (bit_cnt == 5'(FRAME_W)) begin
                sync_n  <= 1'b1;
                done    <= 1'b1;
                gap_cnt <= '0;
                state   <= GAP;
              end else begin
                Dout1 <= sh1[FRAME_W-2];
                Dout2 <= sh2[FRAME_W-2];
                sh1   <= {sh1[FRAME_W-3:0], 1'b0};
                sh2   <= {sh2[FRAME_W-3:0], 1'b0};
              end
            end
          end
          GAP: begin
            if (gap_end) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dac_serial_tx.sv
// Self-checking bench for dac_serial_tx: a frame monitor decodes DAC frames and compares them
// against a scoreboard of words pushed when each pair is offered.
module tb_dac_serial_tx;

  localparam int              HD_A    = 2;
  localparam int              HD_F    = 1;
  localparam int              SH_GAP  = 4;
  localparam logic [3:0]      CTRL_A1 = 4'b0000;
  localparam logic [3:0]      CTRL_A2 = 4'b0000;
  localparam logic [3:0]      CTRL_F1 = 4'b0011;
  localparam logic [3:0]      CTRL_F2 = 4'b0000;

  typedef struct {
    logic        in_frame;
    logic        prev_sclk;
    logic        end_done;
    int          low_cnt;
    int          nbits;
    int          high_cnt;
    int          last_gap;
    int          frames;
    int          dones;
    logic [15:0] w1;
    logic [15:0] w2;
  } mon_t;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready;
  logic [11:0] pdata1, pdata2;
  logic        dac_clk, sync_n, dout1, dout2, busy, done;
  logic        in_valid_f, in_ready_f;
  logic [11:0] pdata1_f, pdata2_f;
  logic        dac_clk_f, sync_n_f, dout1_f, dout2_f, busy_f, done_f;

  int          n_cmp;
  int          n_fail;
  logic [31:0] q_a[$];
  logic [31:0] q_f[$];
  int          gap_q[$];
  mon_t        ma, mf;
  logic        st_a, end_a, st_f, end_f;
  logic [31:0] e_a, e_f;

  dac_serial_tx #(
    .HALF_DIV (HD_A),
    .CTRL1    (CTRL_A1),
    .CTRL2    (CTRL_A2),
    .SYNC_HIGH(SH_GAP)
  ) dut (
    .clk_20M (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .pdata1  (pdata1),
    .pdata2  (pdata2),
    .DAC_clk (dac_clk),
    .sync_n  (sync_n),
    .Dout1   (dout1),
    .Dout2   (dout2),
    .busy    (busy),
    .done    (done)
  );

  dac_serial_tx #(
    .HALF_DIV (HD_F),
    .CTRL1    (CTRL_F1),
    .CTRL2    (CTRL_F2),
    .SYNC_HIGH(SH_GAP)
  ) dut_f (
    .clk_20M (clk),
    .reset   (reset),
    .in_valid(in_valid_f),
    .in_ready(in_ready_f),
    .pdata1  (pdata1_f),
    .pdata2  (pdata2_f),
    .DAC_clk (dac_clk_f),
    .sync_n  (sync_n_f),
    .Dout1   (dout1_f),
    .Dout2   (dout2_f),
    .busy    (busy_f),
    .done    (done_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  function automatic mon_t mon_init();
    mon_t m;
    m.in_frame  = 1'b0;
    m.prev_sclk = 1'b1;
    m.end_done  = 1'b0;
    m.low_cnt   = 0;
    m.nbits     = 0;
    m.high_cnt  = 0;
    m.last_gap  = 0;
    m.frames    = 0;
    m.dones     = 0;
    m.w1        = '0;
    m.w2        = '0;
    return m;
  endfunction

  // Decodes one frame: samples Dout on every DAC_clk falling edge while sync_n is low.
  task automatic mon_step(inout mon_t m, input logic rst, input logic sn, input logic sclk,
                          input logic d1, input logic d2, input logic dn,
                          output logic started, output logic ended);
    started = 1'b0;
    ended   = 1'b0;
    if (dn) m.dones++;
    if (rst) begin
      m.in_frame = 1'b0;
      m.high_cnt = 0;
    end else if (!sn) begin
      if (!m.in_frame) begin
        m.in_frame = 1'b1;
        started    = 1'b1;
        m.last_gap = m.high_cnt;
        m.low_cnt  = 0;
        m.nbits    = 0;
        m.w1       = '0;
        m.w2       = '0;
      end
      m.low_cnt++;
      if (m.prev_sclk && !sclk) begin
        m.w1 = {m.w1[14:0], d1};
        m.w2 = {m.w2[14:0], d2};
        m.nbits++;
      end
    end else begin
      if (m.in_frame) begin
        m.in_frame = 1'b0;
        ended      = 1'b1;
        m.frames++;
        m.end_done = dn;
        m.high_cnt = 0;
      end
      m.high_cnt++;
    end
    m.prev_sclk = sclk;
  endtask

  always @(negedge clk) begin
    mon_step(ma, reset, sync_n, dac_clk, dout1, dout2, done, st_a, end_a);
    if (st_a) gap_q.push_back(ma.last_gap);
    if (end_a) begin
      check("a_frame_expected", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) begin
        e_a = q_a.pop_front();
        check("a_frame_data", {ma.w1, ma.w2}, e_a);
        check("a_frame_len", 32'(ma.low_cnt), 32'(32 * HD_A));
        check("a_frame_bits", 32'(ma.nbits), 32'd16);
        check("a_done_at_end", 32'(ma.end_done), 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    mon_step(mf, reset, sync_n_f, dac_clk_f, dout1_f, dout2_f, done_f, st_f, end_f);
    if (end_f) begin
      check("f_frame_expected", 32'(q_f.size() != 0), 32'd1);
      if (q_f.size() != 0) begin
        e_f = q_f.pop_front();
        check("f_frame_data", {mf.w1, mf.w2}, e_f);
        check("f_frame_len", 32'(mf.low_cnt), 32'(32 * HD_F));
        check("f_frame_bits", 32'(mf.nbits), 32'd16);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_a(input logic [11:0] p1, input logic [11:0] p2, output int waited);
    in_valid = 1'b1;
    pdata1   = p1;
    pdata2   = p2;
    waited   = 0;
    while (!in_ready && waited < 2000) begin
      tick();
      waited++;
    end
    check("send_ready_seen", 32'(in_ready), 32'd1);
    q_a.push_back({CTRL_A1, p1, CTRL_A2, p2});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_frames_a(input int target);
    for (int i = 0; i < 2000 && ma.frames < target; i++) tick();
    check("a_frames_reached", 32'(ma.frames >= target), 32'd1);
  endtask

  initial begin
    int   w;
    int   base;
    int   dn;
    logic bad;

    n_cmp      = 0;
    n_fail     = 0;
    ma         = mon_init();
    mf         = mon_init();
    reset      = 1'b1;
    in_valid   = 1'b0;
    pdata1     = '0;
    pdata2     = '0;
    in_valid_f = 1'b0;
    pdata1_f   = '0;
    pdata2_f   = '0;

    repeat (3) tick();
    check("reset_state", 32'({in_ready, dac_clk, sync_n, dout1, dout2, busy, done}), 32'b1110000);
    reset = 1'b0;
    tick();

    // Single frame: latency, decode, done pulse and busy through the gap.
    gap_q.delete();
    in_valid = 1'b1;
    pdata1   = 12'hA5C;
    pdata2   = 12'h3F0;
    q_a.push_back({CTRL_A1, 12'hA5C, CTRL_A2, 12'h3F0});
    tick();
    in_valid = 1'b0;
    check("latency_n1_sync_high", 32'(sync_n), 32'd1);
    tick();
    check("latency_n2_sync_low", 32'(sync_n), 32'd0);
    check("busy_in_frame", 32'(busy), 32'd1);
    wait_frames_a(1);
    check("busy_gap0", 32'(busy), 32'd1);
    repeat (3) tick();
    check("busy_gap3", 32'(busy), 32'd1);
    tick();
    check("busy_dropped", 32'(busy), 32'd0);
    check("done_once", 32'(ma.dones), 32'd1);

    // Back-to-back frames with a third pair held off while the buffer is full.
    gap_q.delete();
    base = ma.frames;
    send_a(12'hFFF, 12'h000, w);
    send_a(12'h001, 12'h800, w);
    check("in_ready_low_when_full", 32'(in_ready), 32'd0);
    send_a(12'h5A5, 12'hA5A, w);
    check("third_accept_at_frame2_load", 32'({ma.frames == base + 1, ma.low_cnt == 2}), 32'b11);
    check("third_held_in_buffer", 32'(in_ready), 32'd0);
    wait_frames_a(base + 3);
    check("gap_log_size", 32'(gap_q.size()), 32'd3);
    w = gap_q.size() > 1 ? gap_q[1] : -1;
    check("gap_frame1_to_2", 32'(w), 32'(SH_GAP));
    w = gap_q.size() > 2 ? gap_q[2] : -1;
    check("gap_frame2_to_3", 32'(w), 32'(SH_GAP));
    repeat (8) tick();

    // Reset at the 7th falling edge with a second pair waiting in the buffer.
    send_a(12'hFFF, 12'hFFE, w);
    send_a(12'h777, 12'h888, w);
    for (int i = 0; i < 400 && !(ma.in_frame && ma.nbits == 7); i++) tick();
    check("reached_7th_fall", 32'(ma.nbits), 32'd7);
    reset = 1'b1;
    tick();
    check("reset_mid_frame_outputs", 32'({sync_n, dac_clk, dout1, dout2, done, in_ready}), 32'b110001);
    reset = 1'b0;
    q_a.delete();
    base = ma.frames;
    dn   = ma.dones;
    repeat (30) tick();
    check("flush_no_frame", 32'(ma.frames), 32'(base));
    check("no_done_after_reset", 32'(ma.dones), 32'(dn));
    check("in_ready_after_reset", 32'(in_ready), 32'd1);
    send_a(12'h6B1, 12'h2C4, w);
    wait_frames_a(base + 1);

    // HALF_DIV=1 instance with a non-zero control nibble.
    in_valid_f = 1'b1;
    pdata1_f   = 12'h800;
    pdata2_f   = 12'h00F;
    q_f.push_back({CTRL_F1, 12'h800, CTRL_F2, 12'h00F});
    tick();
    in_valid_f = 1'b0;
    for (int i = 0; i < 200 && mf.frames < 1; i++) tick();
    check("f_frames_reached", 32'(mf.frames), 32'd1);

    // Long idle: clock and sync stay high, nothing pulses.
    repeat (10) tick();
    dn  = ma.dones;
    bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!(dac_clk && sync_n && !busy && !done)) bad = 1'b1;
    end
    check("idle_quiet", 32'(bad), 32'd0);
    check("idle_no_done", 32'(ma.dones), 32'(dn));
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("f_queue_drained", 32'(q_f.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
